// File: rtl/hdlverifier_jtag_pkg.sv
// hdlverifier_jtag_pkg
// Shared constants and types for the JTAG command shifter.
//   FRAME_W  : DR frame width for the default 5-bit address / 32-bit data
//              bank (38, or 39 when HDLVERIFIER_JTAG_PARITY_EN is defined)
//   OP_BIT, ADDR_LSB, DATA_LSB, PAR_BIT : field offsets inside a frame
//   state_t  : shifter state machine encoding {IDLE, CAP, SHF}
//   frame_width() : frame width for arbitrary address/data widths
// Optional feature macro: HDLVERIFIER_JTAG_PARITY_EN (even parity bit on
// the top of every frame, in both directions).
`timescale 1ns/1ps

package hdlverifier_jtag_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

`ifdef HDLVERIFIER_JTAG_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int OP_BIT   = 0;
  localparam int ADDR_LSB = 1;
  localparam int DATA_LSB = ADDR_LSB + ADDR_W_DEF;
  localparam int PAR_BIT  = DATA_LSB + DATA_W_DEF;
  localparam int FRAME_W  = PAR_BIT + (PARITY_EN ? 1 : 0);

  // Shift counter: wide enough to tell a 38/39-bit frame from any
  // over-long one, saturating so a runaway shift can never wrap back
  // onto a legal length.
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    SHF  = 2'd2
  } state_t;

  function automatic int frame_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + (PARITY_EN ? 1 : 0);
  endfunction

endpackage

// File: rtl/hdlverifier_jtag_cmd_shifter.sv
// hdlverifier_jtag_cmd_shifter
// JTAG-side command initiator. Deserializes user-DR frames (LSB first:
// op, addr, data[, parity]) into register-bank write / address-select
// commands and serializes {rdata, addr, error[, parity]} back out on tdo.
// Ports:
//   tck, reset         : JTAG clock, synchronous active-high reset
//   sel                : user DR selected; other controls ignored while low
//   capture/shift/update : TAP Capture-DR / Shift-DR / Update-DR
//   tdi, tdo           : serial in (LSB first) / serial out (= sr[0])
//   addr, wdata, write : command to the register bank (write = 1 cycle)
//   rdata              : registered read data from the bank
//   error              : sticky frame error, cleared by a capture
// Optional feature macro: HDLVERIFIER_JTAG_PARITY_EN.
`timescale 1ns/1ps

module hdlverifier_jtag_cmd_shifter
  import hdlverifier_jtag_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              tck,
  input  logic              reset,
  input  logic              sel,
  input  logic              capture,
  input  logic              shift,
  input  logic              update,
  input  logic              tdi,
  output logic              tdo,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              write,
  input  logic [DATA_W-1:0] rdata,
  output logic              error
);

  localparam int FW    = frame_width(ADDR_W, DATA_W);
  localparam int D_LSB = ADDR_LSB + ADDR_W;
  localparam int P_BIT = D_LSB + DATA_W;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FW);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state_reg;
  logic [FW-1:0]     sr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              write_reg;
  logic              error_reg;

  logic [FW-1:0]     cap_word;
  logic              frm_op;
  logic [ADDR_W-1:0] frm_addr;
  logic [DATA_W-1:0] frm_data;
  logic              par_ok;

  always_comb begin
    cap_word             = '0;
    cap_word[P_BIT-1:0]  = {rdata, addr_reg, error_reg};
`ifdef HDLVERIFIER_JTAG_PARITY_EN
    cap_word[P_BIT]      = ^{rdata, addr_reg, error_reg};
`endif
  end

  assign frm_op   = sr_reg[OP_BIT];
  assign frm_addr = sr_reg[D_LSB-1:ADDR_LSB];
  assign frm_data = sr_reg[P_BIT-1:D_LSB];

`ifdef HDLVERIFIER_JTAG_PARITY_EN
  // Even parity: the XOR across the whole frame, parity bit included, is 0.
  assign par_ok = ~(^sr_reg);
`else
  assign par_ok = 1'b1;
`endif

  // Capture only happens in IDLE and update only in CAP/SHF, and update
  // masks capture, so the read-and-clear of error and a newly detected
  // frame error can never land on the same edge.
  always_ff @(posedge tck) begin
    if (reset) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      write_reg <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      write_reg <= 1'b0;
      if (!sel) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (capture && !update) begin
              sr_reg    <= cap_word;
              cnt_reg   <= '0;
              error_reg <= 1'b0;
              state_reg <= CAP;
            end
          end
          CAP, SHF: begin
            if (update) begin
              // cnt == 0 is a capture-only scan: nothing to decode.
              if (cnt_reg != '0) begin
                if (cnt_reg == CNT_FULL && par_ok) begin
                  addr_reg <= frm_addr;
                  if (frm_op) begin
                    wdata_reg <= frm_data;
                    write_reg <= 1'b1;
                  end
                end else begin
                  error_reg <= 1'b1;
                end
              end
              state_reg <= IDLE;
            end else if (shift) begin
              sr_reg <= {tdi, sr_reg[FW-1:1]};
              if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
              end
              state_reg <= SHF;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign tdo   = sr_reg[0];
  assign addr  = addr_reg;
  assign wdata = wdata_reg;
  assign write = write_reg;
  assign error = error_reg;

endmodule
